// File: rtl/vga_timing_gen.sv
// Raster timing generator for 640x480@60 (pixel clock domain).
// All outputs are registered. blank/hs/vs/frame_start are decoded from the
// next-state counter values, so they line up with the DrawX/DrawY they describe.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned PIPE_DELAY = 2
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        blank_d,
  output logic        hs_d,
  output logic        vs_d,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] Y_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        de_q, de_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        fstart_q, fstart_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic [2:0]  sync_now;

  // Next raster position, frame index, and decode of that next position.
  always_comb begin
    x_d    = x_q + 10'd1;
    y_d    = y_q;
    fcnt_d = fcnt_q;
    if (x_q == X_LAST) begin
      x_d = '0;
      if (y_q == Y_LAST) begin
        y_d    = '0;
        fcnt_d = fcnt_q + 16'd1;
      end else begin
        y_d = y_q + 10'd1;
      end
    end
    de_d     = (x_d < X_VIS) && (y_d < Y_VIS);
    hsync_d  = !((x_d >= HS_FIRST) && (x_d <= HS_LAST));
    vsync_d  = !((y_d >= VS_FIRST) && (y_d <= VS_LAST));
    fstart_d = (x_d == '0) && (y_d == '0);
  end

  // Reset parks the raster on the last pixel so release starts frame 0 at (0,0).
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      x_q      <= X_LAST;
      y_q      <= Y_LAST;
      de_q     <= 1'b0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      fstart_q <= 1'b0;
      fcnt_q   <= '1;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      de_q     <= de_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      fstart_q <= fstart_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign blank       = de_q;
  assign hs          = hsync_q;
  assign vs          = vsync_q;
  assign frame_start = fstart_q;
  assign frame_count = fcnt_q;
  assign sync_now    = {de_q, hsync_q, vsync_q};

  generate
    if (PIPE_DELAY == 0) begin : g_nodly
      assign {blank_d, hs_d, vs_d} = sync_now;
    end else begin : g_dly
      localparam int unsigned W = 3 * PIPE_DELAY;
      logic [W-1:0] dly_q, dly_d;

      // Flat shift register: newest triple enters at the bottom, oldest leaves at the top.
      always_comb begin
        dly_d = W'({dly_q, sync_now});
      end

      // Reset flushes every stage to the idle levels instead of draining.
      always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
          dly_q <= {PIPE_DELAY{3'b011}};
        end else begin
          dly_q <= dly_d;
        end
      end

      assign {blank_d, hs_d, vs_d} = dly_q[W-1 -: 3];
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: one default-size instance and two
// shrunken-raster instances (delay 2 and delay 0) share clock and reset.
// Expected outputs come from a closed-form model indexed by cycles since release.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        bl, h, v, bd, hd, vd, fs;
    logic [15:0] fc;
  } obs_t;

  typedef struct packed {
    int hv, hfp, hsw, hbp, vv, vfp, vsw, vbp, d;
  } cfg_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
    obs_t c;
  } trio_t;

  localparam cfg_t CFG_A = '{640, 16, 96, 48, 480, 10, 2, 33, 2};
  localparam cfg_t CFG_B = '{40, 4, 6, 5, 30, 2, 2, 3, 2};
  localparam cfg_t CFG_C = '{40, 4, 6, 5, 30, 2, 2, 3, 0};
  localparam int   FRAME_SM = 55 * 37;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic [9:0]  dx [3];
  logic [9:0]  dy [3];
  logic        o_bl [3];
  logic        o_hs [3];
  logic        o_vs [3];
  logic        o_bd [3];
  logic        o_hd [3];
  logic        o_vd [3];
  logic        o_fs [3];
  logic [15:0] o_fc [3];

  int checks = 0;
  int failures = 0;
  int mt = -1;
  trio_t sb[$];

  always #10 clk = ~clk;

  vga_timing_gen #(.PIPE_DELAY(2)) dut_a (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(dx[0]), .DrawY(dy[0]),
    .blank(o_bl[0]), .hs(o_hs[0]), .vs(o_vs[0]), .blank_d(o_bd[0]),
    .hs_d(o_hd[0]), .vs_d(o_vd[0]), .frame_start(o_fs[0]), .frame_count(o_fc[0])
  );

  vga_timing_gen #(
    .H_VISIBLE(40), .H_FP(4), .H_SYNC(6), .H_BP(5),
    .V_VISIBLE(30), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIPE_DELAY(2)
  ) dut_b (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(dx[1]), .DrawY(dy[1]),
    .blank(o_bl[1]), .hs(o_hs[1]), .vs(o_vs[1]), .blank_d(o_bd[1]),
    .hs_d(o_hd[1]), .vs_d(o_vd[1]), .frame_start(o_fs[1]), .frame_count(o_fc[1])
  );

  vga_timing_gen #(
    .H_VISIBLE(40), .H_FP(4), .H_SYNC(6), .H_BP(5),
    .V_VISIBLE(30), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIPE_DELAY(0)
  ) dut_c (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(dx[2]), .DrawY(dy[2]),
    .blank(o_bl[2]), .hs(o_hs[2]), .vs(o_vs[2]), .blank_d(o_bd[2]),
    .hs_d(o_hd[2]), .vs_d(o_vd[2]), .frame_start(o_fs[2]), .frame_count(o_fc[2])
  );

  // {blank, hs, vs} at cycle t after release; negative t means reset/idle levels.
  function automatic logic [2:0] src_of(int t, cfg_t c);
    int ht, vt, x, y;
    logic bl, h, v;
    if (t < 0) return 3'b011;
    ht = c.hv + c.hfp + c.hsw + c.hbp;
    vt = c.vv + c.vfp + c.vsw + c.vbp;
    x  = t % ht;
    y  = (t / ht) % vt;
    bl = (x < c.hv) && (y < c.vv);
    h  = !((x >= c.hv + c.hfp) && (x < c.hv + c.hfp + c.hsw));
    v  = !((y >= c.vv + c.vfp) && (y < c.vv + c.vfp + c.vsw));
    return {bl, h, v};
  endfunction

  function automatic obs_t model(int t, cfg_t c);
    obs_t o;
    int ht, vt, fr;
    ht = c.hv + c.hfp + c.hsw + c.hbp;
    vt = c.vv + c.vfp + c.vsw + c.vbp;
    fr = ht * vt;
    if (t < 0) begin
      o.x  = 10'(ht - 1);
      o.y  = 10'(vt - 1);
      o.fs = 1'b0;
      o.fc = 16'hFFFF;
    end else begin
      o.x  = 10'(t % ht);
      o.y  = 10'((t / ht) % vt);
      o.fs = ((t % fr) == 0);
      o.fc = 16'((t / fr) % 65536);
    end
    {o.bl, o.h, o.v}    = src_of(t, c);
    {o.bd, o.hd, o.vd}  = src_of(t - c.d, c);
    return o;
  endfunction

  function automatic obs_t got_of(int i);
    obs_t o;
    o.x  = dx[i];
    o.y  = dy[i];
    o.bl = o_bl[i];
    o.h  = o_hs[i];
    o.v  = o_vs[i];
    o.bd = o_bd[i];
    o.hd = o_hd[i];
    o.vd = o_vd[i];
    o.fs = o_fs[i];
    o.fc = o_fc[i];
    return o;
  endfunction

  task automatic chk_obs(string nm, int cyc, obs_t g, obs_t e);
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s cyc=%0d got x=%0d y=%0d bl=%b hs=%b vs=%b bd=%b hd=%b vd=%b fs=%b fc=%h | exp x=%0d y=%0d bl=%b hs=%b vs=%b bd=%b hd=%b vd=%b fs=%b fc=%h",
               nm, cyc, g.x, g.y, g.bl, g.h, g.v, g.bd, g.hd, g.vd, g.fs, g.fc,
               e.x, e.y, e.bl, e.h, e.v, e.bd, e.hd, e.vd, e.fs, e.fc);
    end
  endtask

  task automatic chk_int(string nm, int cyc, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, got, exp);
    end
  endtask

  // One clock of stimulus: drive reset_n, advance the model, queue the expected result.
  task automatic step(logic rn);
    trio_t e;
    reset_n = rn;
    mt = rn ? mt + 1 : -1;
    e.a = model(mt, CFG_A);
    e.b = model(mt, CFG_B);
    e.c = model(mt, CFG_C);
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Stimulus: reset, two clean small frames, targeted resets, random resets, long run.
  initial begin
    repeat (5) step(1'b0);
    repeat (2 * FRAME_SM + 200) step(1'b1);
    step(1'b0);
    while (mt != 10 * 55 + 20) step(1'b1);
    step(1'b0);
    step(1'b1);
    while (mt != 32 * 55 + 46) step(1'b1);
    step(1'b0);
    while (mt != 700) step(1'b1);
    step(1'b0);
    for (int k = 0; k < 12; k++) begin
      int n;
      int r;
      n = int'($urandom_range(3000, 1));
      r = int'($urandom_range(3, 1));
      repeat (n) step(1'b1);
      repeat (r) step(1'b0);
    end
    repeat (8000) step(1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Monitor: pop one expectation per clock edge and compare; also measure pulse widths.
  initial begin
    int   mcyc = 0;
    int   a_hs_run = 0;
    int   b_hs_run = 0;
    int   b_vs_run = 0;
    int   b_last_fs = -1;
    logic rst_seen;
    trio_t e;
    obs_t ga, gb, gc;
    forever begin
      @(posedge clk);
      #1;
      rst_seen = !reset_n;
      ga = got_of(0);
      gb = got_of(1);
      gc = got_of(2);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty cyc=%0d got=0 exp=1", mcyc);
      end else begin
        e = sb.pop_front();
        chk_obs("dut_a", mcyc, ga, e.a);
        chk_obs("dut_b", mcyc, gb, e.b);
        chk_obs("dut_c", mcyc, gc, e.c);
      end
      if (rst_seen) begin
        a_hs_run  = 0;
        b_hs_run  = 0;
        b_vs_run  = 0;
        b_last_fs = -1;
      end else begin
        if (!ga.h) a_hs_run++;
        else if (a_hs_run > 0) begin
          chk_int("hs_width_a", mcyc, a_hs_run, 96);
          a_hs_run = 0;
        end
        if (!gb.h) b_hs_run++;
        else if (b_hs_run > 0) begin
          chk_int("hs_width_b", mcyc, b_hs_run, 6);
          b_hs_run = 0;
        end
        if (!gb.v) b_vs_run++;
        else if (b_vs_run > 0) begin
          chk_int("vs_width_b", mcyc, b_vs_run, 2 * 55);
          b_vs_run = 0;
        end
        if (gb.fs) begin
          if (b_last_fs >= 0) chk_int("frame_period_b", mcyc, mcyc - b_last_fs, FRAME_SM);
          b_last_fs = mcyc;
        end
      end
      mcyc++;
    end
  end

  // Guard against a stalled run.
  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 640x480 @ 60 Hz display path. It is driven by the 25 MHz pixel clock and produces the `DrawX`/`DrawY` pixel coordinates and the `blank` display-enable consumed by the background tile mappers and sprite stages. It also produces horizontal and vertical sync, and copies of `hs`/`vs`/`blank` delayed by a parameterised number of cycles, so the sync pins line up with RGB from the registered ROM/palette pipeline. A frame-start pulse and a frame counter are provided for game-logic sequencing.

## Interface

**Parameters**
- `H_VISIBLE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, in cycles
- `H_SYNC`, 96: horizontal sync width, in cycles
- `H_BP`, 48: horizontal back porch, in cycles
- `V_VISIBLE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vertical sync width, in lines
- `V_BP`, 33: vertical back porch, in lines
- `PIPE_DELAY`, 2: delay from `blank`/`hs`/`vs` to `blank_d`/`hs_d`/`vs_d`, in cycles. Legal range is 0..7.

**Ports**
- `vga_clk` in 1: pixel clock. This is the only clock.
- `reset_n` in 1: synchronous, active-low reset.
- `DrawX` out 10: current horizontal count, 0..799.
- `DrawY` out 10: current vertical count, 0..524.
- `blank` out 1: display enable. 1 = visible pixel, 0 = blanking.
- `hs` out 1: horizontal sync, active-low.
- `vs` out 1: vertical sync, active-low.
- `blank_d` out 1: `blank` delayed by `PIPE_DELAY` cycles.
- `hs_d` out 1: `hs` delayed by `PIPE_DELAY` cycles.
- `vs_d` out 1: `vs` delayed by `PIPE_DELAY` cycles.
- `frame_start` out 1: one-cycle pulse, high while (`DrawX`,`DrawY`) = (0,0).
- `frame_count` out 16: frame index.

## Operation

**Totals**
- H_TOTAL = sum of the H_* parameters (800 by default).
- V_TOTAL = sum of the V_* parameters (525 by default).

**Counters**
- `DrawX` increments every cycle.
- At `H_TOTAL-1`, `DrawX` wraps to 0 and `DrawY` increments.
- When `DrawY` is at `V_TOTAL-1` at the same wrap, `DrawY` wraps to 0.
- The counters have no enable and no stall.

**Decode** (all functions of the current `DrawX`/`DrawY`)
- `blank` = (`DrawX` < `H_VISIBLE`) && (`DrawY` < `V_VISIBLE`).
- `hs` = 0 iff `DrawX` is in [`H_VISIBLE+H_FP`, `H_VISIBLE+H_FP+H_SYNC-1`], i.e. [656, 751] by default.
- `vs` = 0 iff `DrawY` is in [`V_VISIBLE+V_FP`, `V_VISIBLE+V_FP+V_SYNC-1`], i.e. [490, 491] by default.
  - `vs` is asserted for whole lines, including every cycle of those lines.
- `frame_start` = (`DrawX`==0 && `DrawY`==0).

**Registered outputs**
- `blank`, `hs`, `vs` and `frame_start` are registered outputs. Derive them from the next-state counter values so they are valid in the same cycle as the `DrawX`/`DrawY` they describe.
- No output may be a combinational decode of the counter registers.

**Frame counter**
- `frame_count` increments (mod 2^16) on the edge where the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0).
- It therefore changes in the same cycle `frame_start` rises.

**Delay line**
- Three-bit shift register of depth `PIPE_DELAY`.
- `PIPE_DELAY` = 0 means `*_d` equals the undelayed outputs exactly.

## Timing

**Reset state** (synchronous: takes effect on any edge with `reset_n`=0, regardless of position)
- Counters load the last position of the frame: `DrawX`=799, `DrawY`=524.
- `blank`=0, `hs`=1, `vs`=1, `frame_start`=0.
- `frame_count`=16'hFFFF.
- Every delay-line stage loads `blank_d`=0, `hs_d`=1, `vs_d`=1.

**First cycle after reset** (first edge with `reset_n`=1)
- `DrawX`=0, `DrawY`=0, `blank`=1, `frame_start`=1, `frame_count`=0.
- The first frame after reset is always frame 0 and starts immediately.

**Reset mid-frame**
- The current line and frame are abandoned with no partial sync.
- Delayed outputs are flushed immediately, not drained.

**Period and width rules**
- Line period is exactly `H_TOTAL` cycles.
- Frame period is exactly `H_TOTAL*V_TOTAL` cycles, i.e. 420000 by default.
- The `hs` low width is exactly `H_SYNC` cycles.
- The `vs` low width is exactly `V_SYNC*H_TOTAL` cycles.

**Latency**
- `*_d` lags its source by exactly `PIPE_DELAY` edges.
- `DrawX`/`DrawY` have zero latency relative to `blank`.

## Test plan

- **Reset and release:** hold `reset_n`=0 for 5 cycles.
  - During reset: `DrawX`=799, `DrawY`=524, `blank`=0, `hs`=`vs`=1, `frame_count`=FFFF, `blank_d`=0.
  - First edge after release: `DrawX`=0, `DrawY`=0, `blank`=1, `frame_start`=1, `frame_count`=0.
- **Line timing:**
  - `blank` falls when `DrawX` goes from 639 to 640.
  - `hs` is low for exactly `DrawX` 656..751 (96 cycles).
  - `DrawX` returns to 0 800 cycles after it was last 0.
  - `DrawY` increments only at that wrap.
- **Frame timing:**
  - `vs` is low for `DrawY` 490..491, i.e. 1600 consecutive cycles.
  - Consecutive `frame_start` pulses are 420000 cycles apart.
  - `frame_count` steps 0 to 1 to 2 over two frames.
  - `blank` is 0 on all of lines 480..524.
- **Delay alignment:**
  - With `PIPE_DELAY`=2: `blank_d`, `hs_d` and `vs_d` equal `blank`, `hs` and `vs` from 2 cycles earlier, on every cycle of a full frame.
  - With `PIPE_DELAY`=0: they are identical to the undelayed outputs.
- **Reset mid-frame:**
  - Pulse `reset_n`=0 for one cycle while `DrawX`=300, `DrawY`=100.
  - Next cycle shows the reset state with all delay stages flushed.
  - The following cycle is (0,0) with `frame_start`=1 and `frame_count`=0.
- **Reset during sync:**
  - Assert reset while `hs`=0 and `vs`=0 (`DrawX`=700, `DrawY`=490).
  - `hs`, `vs`, `hs_d` and `vs_d` all read 1 on the next cycle.
